// File: rtl/cache_arb_pkg.sv
// Shared types for the cache port arbiter: FSM states, port ids and the
// latched request payload that drives the cache while a grant is active.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         vec_mode;
    logic [3:0]   vec_mask;
    logic [127:0] vec_wdata;
  } cache_req_t;

  // Under contention round-robin hands the port to whoever was not served last.
  function automatic logic pick_port(input logic req0,
                                     input logic req1,
                                     input logic last_grant,
                                     input logic round_robin);
    logic win;
    if (req0 && req1) begin
      win = round_robin ? ~last_grant : PORT_DATA;
    end else if (req0) begin
      win = PORT_DATA;
    end else begin
      win = PORT_FETCH;
    end
    return win;
  endfunction

endpackage

// File: rtl/cache_port_arbiter.sv
// Shares one cache port between the data/memory stage (port 0) and
// instruction fetch (port 1); one transaction in flight at a time.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [31:0]  p0_addr,
  input  logic [31:0]  p0_wdata,
  input  logic         p0_vec_mode,
  input  logic [3:0]   p0_vec_mask,
  input  logic [127:0] p0_vec_wdata,
  output logic         p0_done,
  output logic [31:0]  p0_rdata,
  output logic [127:0] p0_vec_rdata,
  input  logic         p1_req,
  input  logic [31:0]  p1_addr,
  output logic         p1_done,
  output logic [31:0]  p1_rdata,
  output logic [31:0]  addr_cache,
  output logic [31:0]  wdata_cache,
  input  logic [31:0]  rdata_cache,
  output logic         write_enable_cache,
  output logic         read_enable_cache,
  input  logic         miss_cache,
  output logic [127:0] vec_wdata_cache,
  input  logic [127:0] vec_rdata_cache,
  output logic         vec_mode_cache,
  output logic [3:0]   vec_mask_cache,
  output logic [31:0]  stall_cycles,
  output arb_state_e   dbg_state
);

  // Handshake: a requester raises req with its payload and holds req until
  // its done pulse; payload is only sampled in the IDLE cycle that grants it.
  // The cache side sees a strobe every ACCESS cycle and completes on the
  // first cycle with miss_cache low.

  arb_state_e   state_q, state_d;
  cache_req_t   req_q, req_d;
  logic         grant_q, grant_d;
  logic [31:0]  p0_rdata_q, p0_rdata_d;
  logic [127:0] p0_vec_rdata_q, p0_vec_rdata_d;
  logic [31:0]  p1_rdata_q, p1_rdata_d;
  logic [31:0]  stall_q, stall_d;

  cache_req_t   p0_payload;
  cache_req_t   p1_payload;

  always_comb begin
    p0_payload           = '0;
    p0_payload.we        = p0_we;
    p0_payload.addr      = p0_addr;
    p0_payload.wdata     = p0_wdata;
    p0_payload.vec_mode  = p0_vec_mode;
    p0_payload.vec_mask  = p0_vec_mask;
    p0_payload.vec_wdata = p0_vec_wdata;

    p1_payload           = '0;
    p1_payload.addr      = p1_addr;
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    grant_d        = grant_q;
    p0_rdata_d     = p0_rdata_q;
    p0_vec_rdata_d = p0_vec_rdata_q;
    p1_rdata_d     = p1_rdata_q;
    stall_d        = stall_q;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d = pick_port(p0_req, p1_req, grant_q, ROUND_ROBIN);
          req_d   = (grant_d == PORT_DATA) ? p0_payload : p1_payload;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (miss_cache) begin
          stall_d = stall_q + 32'd1;
        end else begin
          // Writes leave the requester's last read data untouched.
          if (!req_q.we) begin
            if (grant_q == PORT_DATA) begin
              p0_rdata_d     = rdata_cache;
              p0_vec_rdata_d = vec_rdata_cache;
            end else begin
              p1_rdata_d     = rdata_cache;
            end
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      req_q          <= '0;
      grant_q        <= PORT_FETCH;
      p0_rdata_q     <= '0;
      p0_vec_rdata_q <= '0;
      p1_rdata_q     <= '0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      grant_q        <= grant_d;
      p0_rdata_q     <= p0_rdata_d;
      p0_vec_rdata_q <= p0_vec_rdata_d;
      p1_rdata_q     <= p1_rdata_d;
      stall_q        <= stall_d;
    end
  end

  assign read_enable_cache  = (state_q == ACCESS) && !req_q.we;
  assign write_enable_cache = (state_q == ACCESS) && req_q.we;
  assign addr_cache         = req_q.addr;
  assign wdata_cache        = req_q.wdata;
  assign vec_mode_cache     = req_q.vec_mode;
  assign vec_mask_cache     = req_q.vec_mask;
  assign vec_wdata_cache    = req_q.vec_wdata;

  assign p0_done      = (state_q == RESP) && (grant_q == PORT_DATA);
  assign p1_done      = (state_q == RESP) && (grant_q == PORT_FETCH);
  assign p0_rdata     = p0_rdata_q;
  assign p0_vec_rdata = p0_vec_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of grants, latency and data.
module tb_cache_port_arbiter;
  import cache_arb_pkg::*;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         vmode;
    logic [3:0]   vmask;
    logic [127:0] vwdata;
  } txn_t;

  logic clk = 1'b0;
  logic rstn;
  logic p0_req, p0_we, p0_vec_mode, p1_req, miss_cache;
  logic [31:0] p0_addr, p0_wdata, p1_addr, rdata_cache;
  logic [3:0] p0_vec_mask;
  logic [127:0] p0_vec_wdata, vec_rdata_cache;

  logic p0_done, p1_done, write_enable_cache, read_enable_cache, vec_mode_cache;
  logic [31:0] p0_rdata, p1_rdata, addr_cache, wdata_cache, stall_cycles;
  logic [127:0] p0_vec_rdata, vec_wdata_cache;
  logic [3:0] vec_mask_cache;
  arb_state_e dut_state;

  logic f_p0_done, f_p1_done, f_we, f_re, f_vmode;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_addr, f_wdata, f_stall;
  logic [127:0] f_p0_vrdata, f_vwdata;
  logic [3:0] f_vmask;
  arb_state_e f_state;

  int n_checks = 0;
  int n_fail = 0;

  bit pend [2];
  txn_t pl [2];
  int last_grant;
  logic [31:0] exp_stall, exp_p0_rd, exp_p1_rd;
  logic [127:0] exp_p0_vrd;

  cache_port_arbiter #(.ROUND_ROBIN(1'b1)) u_dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_vec_mode(p0_vec_mode), .p0_vec_mask(p0_vec_mask), .p0_vec_wdata(p0_vec_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_vec_rdata(p0_vec_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .addr_cache(addr_cache), .wdata_cache(wdata_cache), .rdata_cache(rdata_cache),
    .write_enable_cache(write_enable_cache), .read_enable_cache(read_enable_cache),
    .miss_cache(miss_cache), .vec_wdata_cache(vec_wdata_cache),
    .vec_rdata_cache(vec_rdata_cache), .vec_mode_cache(vec_mode_cache),
    .vec_mask_cache(vec_mask_cache), .stall_cycles(stall_cycles), .dbg_state(dut_state)
  );

  // Fixed-priority twin sees identical inputs; its timing matches the
  // round-robin instance because latency never depends on which port wins.
  cache_port_arbiter #(.ROUND_ROBIN(1'b0)) u_dut_fp (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_vec_mode(p0_vec_mode), .p0_vec_mask(p0_vec_mask), .p0_vec_wdata(p0_vec_wdata),
    .p0_done(f_p0_done), .p0_rdata(f_p0_rdata), .p0_vec_rdata(f_p0_vrdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_done(f_p1_done), .p1_rdata(f_p1_rdata),
    .addr_cache(f_addr), .wdata_cache(f_wdata), .rdata_cache(rdata_cache),
    .write_enable_cache(f_we), .read_enable_cache(f_re),
    .miss_cache(miss_cache), .vec_wdata_cache(f_vwdata),
    .vec_rdata_cache(vec_rdata_cache), .vec_mode_cache(f_vmode),
    .vec_mask_cache(f_vmask), .stall_cycles(f_stall), .dbg_state(f_state)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic txn_t mk_txn(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic vmode,
                                  input logic [3:0] vmask, input logic [127:0] vwdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    t.vmode = vmode; t.vmask = vmask; t.vwdata = vwdata;
    return t;
  endfunction

  // Fetch requests are always plain scalar reads.
  function automatic txn_t rand_txn(input int port);
    if (port == 0)
      return mk_txn(1'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom), rand128());
    return mk_txn(1'b0, $urandom, 32'h0, 1'b0, 4'h0, 128'h0);
  endfunction

  function automatic int pick(input bit r0, input bit r1, input int last, input bit rr);
    if (r0 && r1) return rr ? (1 - last) : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic drive_reqs();
    p0_req = pend[0];
    p0_we = pl[0].we; p0_addr = pl[0].addr; p0_wdata = pl[0].wdata;
    p0_vec_mode = pl[0].vmode; p0_vec_mask = pl[0].vmask; p0_vec_wdata = pl[0].vwdata;
    p1_req = pend[1];
    p1_addr = pl[1].addr;
  endtask

  task automatic model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    pl[0] = mk_txn(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 128'h0);
    pl[1] = pl[0];
    last_grant = 1;
    exp_stall = 32'h0; exp_p0_rd = 32'h0; exp_p1_rd = 32'h0; exp_p0_vrd = 128'h0;
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge
  // of the IDLE cycle that follows the done pulse.
  task automatic run_txn(input int k, input logic [31:0] hit_rd, input logic [127:0] hit_vrd);
    int w, wf;
    txn_t g;
    drive_reqs();
    chk1("idle_rd_en", read_enable_cache, 1'b0);
    chk1("idle_wr_en", write_enable_cache, 1'b0);
    chk1("idle_p0_done", p0_done, 1'b0);
    chk1("idle_p1_done", p1_done, 1'b0);
    w  = pick(pend[0], pend[1], last_grant, 1'b1);
    wf = pick(pend[0], pend[1], last_grant, 1'b0);
    g  = pl[w];
    @(negedge clk);
    for (int c = 0; c <= k; c++) begin
      if (w == 0) begin
        p0_we = 1'($urandom); p0_addr = $urandom; p0_wdata = $urandom;
        p0_vec_mode = 1'($urandom); p0_vec_mask = 4'($urandom); p0_vec_wdata = rand128();
      end else begin
        p1_addr = $urandom;
      end
      miss_cache      = (c < k);
      rdata_cache     = (c == k) ? hit_rd : $urandom;
      vec_rdata_cache = (c == k) ? hit_vrd : rand128();
      chk1("acc_rd_en", read_enable_cache, !g.we);
      chk1("acc_wr_en", write_enable_cache, g.we);
      chk32("acc_addr", addr_cache, g.addr);
      chk32("acc_wdata", wdata_cache, g.wdata);
      chk1("acc_vmode", vec_mode_cache, g.vmode);
      chk32("acc_vmask", 32'(vec_mask_cache), 32'(g.vmask));
      if (w == 0) chk128("acc_vwdata", vec_wdata_cache, g.vwdata);
      chk1("acc_p0_done", p0_done, 1'b0);
      chk1("acc_p1_done", p1_done, 1'b0);
      @(negedge clk);
    end
    miss_cache = 1'b0;
    if (!g.we) begin
      if (w == 0) begin
        exp_p0_rd = hit_rd; exp_p0_vrd = hit_vrd;
      end else begin
        exp_p1_rd = hit_rd;
      end
    end
    exp_stall = exp_stall + 32'(k);
    chk1("resp_p0_done", p0_done, w == 0);
    chk1("resp_p1_done", p1_done, w == 1);
    chk1("resp_fp_p0_done", f_p0_done, wf == 0);
    chk1("resp_fp_p1_done", f_p1_done, wf == 1);
    chk1("resp_rd_en", read_enable_cache, 1'b0);
    chk1("resp_wr_en", write_enable_cache, 1'b0);
    chk32("resp_p0_rdata", p0_rdata, exp_p0_rd);
    chk128("resp_p0_vrdata", p0_vec_rdata, exp_p0_vrd);
    chk32("resp_p1_rdata", p1_rdata, exp_p1_rd);
    chk32("resp_stall", stall_cycles, exp_stall);
    last_grant = w;
    pend[w] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    miss_cache = 1'b0; rdata_cache = 32'h0; vec_rdata_cache = 128'h0;
    model_reset();
    drive_reqs();
    repeat (2) @(negedge clk);

    // Reset values on both instances.
    chk32("rst_state", 32'(dut_state), 32'(IDLE));
    chk1("rst_rd_en", read_enable_cache, 1'b0);
    chk1("rst_wr_en", write_enable_cache, 1'b0);
    chk1("rst_p0_done", p0_done, 1'b0);
    chk1("rst_p1_done", p1_done, 1'b0);
    chk32("rst_addr", addr_cache, 32'h0);
    chk32("rst_wdata", wdata_cache, 32'h0);
    chk1("rst_vmode", vec_mode_cache, 1'b0);
    chk32("rst_vmask", 32'(vec_mask_cache), 32'h0);
    chk128("rst_vwdata", vec_wdata_cache, 128'h0);
    chk32("rst_p0_rdata", p0_rdata, 32'h0);
    chk128("rst_p0_vrdata", p0_vec_rdata, 128'h0);
    chk32("rst_p1_rdata", p1_rdata, 32'h0);
    chk32("rst_stall", stall_cycles, 32'h0);
    chk32("rst_fp_state", 32'(f_state), 32'(IDLE));
    chk1("rst_fp_strobes", f_we | f_re | f_p0_done | f_p1_done | f_vmode, 1'b0);
    chk128("rst_fp_data", {f_p0_rdata, f_p1_rdata, f_addr, f_wdata} | f_p0_vrdata | f_vwdata
           | {96'h0, f_stall} | {124'h0, f_vmask}, 128'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Fetch read hit.
    pl[1] = mk_txn(1'b0, 32'h100, 32'h0, 1'b0, 4'h0, 128'h0);
    pend[1] = 1'b1;
    run_txn(0, 32'hDEADBEEF, rand128());

    // Scalar write with three miss cycles.
    pl[0] = mk_txn(1'b1, 32'h2000, 32'h12345678, 1'b0, 4'h0, rand128());
    pend[0] = 1'b1;
    run_txn(3, $urandom, rand128());

    // Both ports held continuously: alternation vs. fixed priority.
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) pl[0] = rand_txn(0);
      if (!pend[1]) pl[1] = rand_txn(1);
      pend[0] = 1'b1; pend[1] = 1'b1;
      run_txn(0, $urandom, rand128());
    end
    pend[0] = 1'b0;
    pend[1] = 1'b1;
    run_txn(0, $urandom, rand128());

    // Vector read with two miss cycles.
    pend[1] = 1'b0;
    pl[0] = mk_txn(1'b0, $urandom, $urandom, 1'b1, 4'b1010, rand128());
    pend[0] = 1'b1;
    run_txn(2, $urandom, rand128());

    // Reset during a missing access abandons it.
    pl[0] = mk_txn(1'b1, $urandom, $urandom, 1'b0, 4'h0, rand128());
    pend[0] = 1'b1;
    drive_reqs();
    @(negedge clk);
    miss_cache = 1'b1;
    chk1("mid_wr_en_before", write_enable_cache, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk1("mid_rst_wr_en", write_enable_cache, 1'b0);
    chk1("mid_rst_rd_en", read_enable_cache, 1'b0);
    chk1("mid_rst_fp_wr_en", f_we, 1'b0);
    model_reset();
    drive_reqs();
    miss_cache = 1'b0;
    @(negedge clk);
    chk1("mid_rst_p0_done", p0_done, 1'b0);
    chk1("mid_rst_p1_done", p1_done, 1'b0);
    chk32("mid_rst_stall", stall_cycles, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk1("post_rst_p0_done", p0_done, 1'b0);
    pl[1] = rand_txn(1);
    pend[1] = 1'b1;
    run_txn(1, $urandom, rand128());

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
        drive_reqs();
        @(negedge clk);
        chk1("gap_rd_en", read_enable_cache, 1'b0);
        chk1("gap_wr_en", write_enable_cache, 1'b0);
        chk1("gap_done", p0_done | p1_done, 1'b0);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          pl[p] = rand_txn(p);
        end
      end
      if (!pend[0] && !pend[1]) begin
        int p;
        p = int'($urandom_range(0, 1));
        pend[p] = 1'b1;
        pl[p] = rand_txn(p);
      end
      run_txn(int'($urandom_range(0, 3)), $urandom, rand128());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
